// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers one command's payload, then sends header, payload and parity to a router port.
module router_pkt_tx #(
    parameter int IFG     = 2,
    parameter int MAX_LEN = 63
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       pay_valid,
    output logic       pay_ready,
    input  logic [7:0] pay_data,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_done,
    output logic       cmd_err,
    output logic       tx_active
);
    localparam int CW = $clog2(IFG) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, HDR, PAY, PAR, GAP} state_e;
    state_e        state_q, state_d;
    logic [7:0]    hdr_q, hdr_d, par_q, par_d;
    logic [5:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d, err_q, err_d, wr_en, last;
    logic [7:0]    mem_q [MAX_LEN];

    assign last = idx_q == hdr_q[7:2] - 6'd1;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            hdr_q   <= '0;
            par_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            par_q   <= par_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // payload storage is deliberately left unreset
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[idx_q] <= pay_data;
    end

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        par_d   = par_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_addr == 2'd3 || cmd_len == 6'd0) begin
                    err_d = 1'b1;
                end else begin
                    hdr_d   = {cmd_len, cmd_addr};
                    par_d   = {cmd_len, cmd_addr};
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: if (pay_valid) begin
                wr_en   = 1'b1;
                par_d   = par_q ^ pay_data;
                idx_d   = last ? 6'd0 : idx_q + 6'd1;
                state_d = last ? HDR : LOAD;
            end
            HDR: if (!busy) state_d = PAY;
            PAY: if (!busy) begin
                idx_d   = idx_q + 6'd1;
                state_d = last ? PAR : PAY;
            end
            PAR: if (!busy) begin
                cnt_d   = '0;
                done_d  = 1'b1;
                state_d = GAP;
            end
            GAP: begin
                // saturate so a long busy in GAP cannot wrap the idle count
                if (cnt_q < CW'(IFG - 1)) cnt_d = cnt_q + CW'(1);
                if (cnt_q >= CW'(IFG - 1) && !busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pkt_valid = state_q == HDR || state_q == PAY;
    assign data_out  = state_q == HDR ? hdr_q :
                       state_q == PAY ? mem_q[idx_q] :
                       state_q == PAR ? par_q : 8'h00;
    assign cmd_ready = state_q == IDLE;
    assign pay_ready = state_q == LOAD;
    assign tx_active = state_q != IDLE;
    assign tx_done   = done_q;
    assign cmd_err   = err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: table-driven cycle vectors plus directed multi-cycle packet sequences.
module tb_router_pkt_tx;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0, pay_valid = 1'b0, busy = 1'b0;
    logic [1:0] cmd_addr = '0;
    logic [5:0] cmd_len = '0;
    logic [7:0] pay_data = '0;
    logic       cmd_ready, pay_ready, pkt_valid, tx_done, cmd_err, tx_active;
    logic [7:0] data_out;

    int errors = 0, checks = 0;
    logic [7:0] pay_b [64];
    bit busy_plan [400];

    typedef struct {
        logic       cv;
        logic [1:0] ca;
        logic [5:0] cl;
        logic       pv;
        logic [7:0] pd;
        logic [13:0] e;
    } vec_t;
    vec_t tbl [16];

    router_pkt_tx #(.IFG(2), .MAX_LEN(63)) dut (
        .clock(clock), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .pay_valid(pay_valid), .pay_ready(pay_ready),
        .pay_data(pay_data), .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
        .tx_done(tx_done), .cmd_err(cmd_err), .tx_active(tx_active)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic logic [13:0] ex(logic pv, logic [7:0] d, logic dn, logic er, logic cr, logic pr, logic ac);
        return {pv, d, dn, er, cr, pr, ac};
    endfunction

    function automatic vec_t mk(logic cv, logic [1:0] ca, logic [5:0] cl, logic pv, logic [7:0] pd, logic [13:0] e);
        vec_t v;
        v.cv = cv; v.ca = ca; v.cl = cl; v.pv = pv; v.pd = pd; v.e = e;
        return v;
    endfunction

    function automatic logic [13:0] outs();
        return {pkt_valid, data_out, tx_done, cmd_err, cmd_ready, pay_ready, tx_active};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_pkt(input string nm, input logic [1:0] a, input logic [5:0] l);
        int w = 0, miss = 0;
        while (!cmd_ready && w < 50) begin
            step();
            w++;
        end
        chk({nm, " cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_addr = a; cmd_len = l;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < l; i++) begin
            if (!pay_ready) miss++;
            pay_valid = 1'b1; pay_data = pay_b[i];
            step();
        end
        pay_valid = 1'b0;
        chk({nm, " load_ready"}, miss, 0);
    endtask

    task automatic tx_pkt(input string nm, input logic [1:0] a, input logic [5:0] l,
                          input int exp_cyc, input int hold_pos, input int hold_exp);
        logic [7:0] exp_s [$];
        logic [7:0] p, got_par;
        int hold [65];
        int pos = 0, bad = 0, cyc = 0, g;
        bit fin = 0;
        p = {l, a};
        exp_s.push_back(p);
        for (int i = 0; i < l; i++) begin
            exp_s.push_back(pay_b[i]);
            p ^= pay_b[i];
        end
        exp_s.push_back(p);
        foreach (hold[i]) hold[i] = 0;
        load_pkt(nm, a, l);
        chk({nm, " hdr_latency"}, {pkt_valid, data_out}, {1'b1, l, a});
        for (int k = 0; k < 400 && !fin; k++) begin
            busy = busy_plan[k];
            if (pkt_valid) begin
                if (pos > l) bad++;
                else begin
                    hold[pos]++;
                    if (data_out !== exp_s[pos]) bad++;
                end
                if (!busy) pos++;
            end else if (pos == l + 1) begin
                if (data_out !== exp_s[pos]) bad++;
                if (!busy) begin
                    got_par = data_out;
                    cyc = k + 1;
                    fin = 1;
                end
            end else bad++;
            step();
        end
        busy = 1'b0;
        chk({nm, " stream"}, bad, 0);
        chk({nm, " bytes"}, pos, l + 1);
        chk({nm, " parity"}, got_par, exp_s[l + 1]);
        chk({nm, " wire_cycles"}, cyc, exp_cyc);
        chk({nm, " hold"}, hold[hold_pos], hold_exp);
        chk({nm, " tx_done"}, {tx_done, pkt_valid}, 2'b10);
        g = 1;
        step();
        chk({nm, " tx_done_clr"}, {tx_done, pkt_valid}, 2'b00);
        while (!cmd_ready && g < 50) begin
            g++;
            step();
        end
        chk({nm, " gap"}, g, 2);
    endtask

    initial begin
        tbl[0]  = mk(1, 2'd1, 6'd3, 0, 8'h00, ex(0, 8'h00, 0, 0, 1, 0, 0));
        tbl[1]  = mk(0, 2'd0, 6'd0, 1, 8'hA1, ex(0, 8'h00, 0, 0, 0, 1, 1));
        tbl[2]  = mk(0, 2'd0, 6'd0, 1, 8'hB2, ex(0, 8'h00, 0, 0, 0, 1, 1));
        tbl[3]  = mk(0, 2'd0, 6'd0, 1, 8'hC3, ex(0, 8'h00, 0, 0, 0, 1, 1));
        tbl[4]  = mk(0, 2'd0, 6'd0, 1, 8'hFF, ex(1, 8'h0D, 0, 0, 0, 0, 1));
        tbl[5]  = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(1, 8'hA1, 0, 0, 0, 0, 1));
        tbl[6]  = mk(1, 2'd2, 6'd7, 0, 8'h00, ex(1, 8'hB2, 0, 0, 0, 0, 1));
        tbl[7]  = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(1, 8'hC3, 0, 0, 0, 0, 1));
        tbl[8]  = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'hDD, 0, 0, 0, 0, 1));
        tbl[9]  = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'h00, 1, 0, 0, 0, 1));
        tbl[10] = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'h00, 0, 0, 0, 0, 1));
        tbl[11] = mk(1, 2'd3, 6'd5, 1, 8'h55, ex(0, 8'h00, 0, 0, 1, 0, 0));
        tbl[12] = mk(0, 2'd0, 6'd0, 1, 8'h66, ex(0, 8'h00, 0, 1, 1, 0, 0));
        tbl[13] = mk(1, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'h00, 0, 0, 1, 0, 0));
        tbl[14] = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'h00, 0, 1, 1, 0, 0));
        tbl[15] = mk(0, 2'd0, 6'd0, 0, 8'h00, ex(0, 8'h00, 0, 0, 1, 0, 0));

        repeat (2) @(posedge clock);
        #1;
        chk("reset_outputs", outs(), ex(0, 8'h00, 0, 0, 1, 0, 0));
        resetn = 1'b1;

        for (int r = 0; r < 16; r++) begin
            cmd_valid = tbl[r].cv; cmd_addr = tbl[r].ca; cmd_len = tbl[r].cl;
            pay_valid = tbl[r].pv; pay_data = tbl[r].pd;
            chk($sformatf("vec%0d", r), outs(), tbl[r].e);
            step();
        end
        cmd_valid = 1'b0; pay_valid = 1'b0;

        pay_b[0] = 8'hA1; pay_b[1] = 8'hB2; pay_b[2] = 8'hC3;
        foreach (busy_plan[i]) busy_plan[i] = 0;
        for (int k = 2; k <= 4; k++) busy_plan[k] = 1;
        tx_pkt("t2", 2'd1, 6'd3, 8, 2, 4);

        foreach (busy_plan[i]) busy_plan[i] = 0;
        pay_b[0] = 8'($urandom);
        tx_pkt("t4a", 2'd2, 6'd1, 3, 0, 1);
        for (int i = 0; i < 63; i++) pay_b[i] = 8'($urandom);
        tx_pkt("t4b", 2'd0, 6'd63, 65, 0, 1);

        for (int i = 0; i < 10; i++) pay_b[i] = 8'($urandom);
        load_pkt("t5", 2'd0, 6'd10);
        repeat (4) step();
        chk("t5 in_pay", {pkt_valid, tx_active}, 2'b11);
        #2 resetn = 1'b0;
        #1;
        chk("t5 async_abort", outs(), ex(0, 8'h00, 0, 0, 1, 0, 0));
        @(posedge clock);
        #1 resetn = 1'b1;
        for (int i = 0; i < 10; i++) pay_b[i] = 8'($urandom);
        tx_pkt("t5b", 2'd2, 6'd10, 12, 0, 1);

        for (int i = 0; i < 4; i++) pay_b[i] = 8'($urandom);
        for (int k = 1; k <= 20; k++) busy_plan[k] = 1;
        tx_pkt("t6", 2'd1, 6'd4, 26, 1, 21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
